voice_scheduler_mixer: RTL and testbench
========================================

Name: voice_scheduler_mixer

Overview:
Upstream/downstream companion of the sequential 3-voice generator. Once per sample_tick_i it time-multiplexes the generator over voices 0..2 and drives each voice's control words. It captures each returned waveform, scales it by a per-voice 8-bit envelope level and sums the three results. The output is one signed 12-bit mixed sample per tick, handed to the filter/DAC stage.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait for voice_ready_i after start_o before the voice is abandoned (range 4..255)

Ports:
clk_i  in  1  system clock (50 MHz)
rst_ni  in  1  asynchronous reset, active low
sample_tick_i  in  1  one-cycle pulse, start of a sample frame
status_clr_i  in  1  clears the sticky flags
freq_words_i  in  48  voice v control word at [16v+15:16v]
pw_words_i  in  36  voice v pulse width at [12v+11:12v]
wave_sels_i  in  12  voice v wave select at [4v+3:4v]
sync_en_i  in  3  per-voice hard sync enable
ring_en_i  in  3  per-voice ring-mod enable
env_levels_i  in  24  voice v envelope level, unsigned, at [8v+7:8v]
mute_i  in  3  per-voice mute
start_o  out  1  start pulse to the generator
act_voice_o  out  2  voice index to the generator
freq_word_o  out  16  selected freq word
pw_word_o  out  12  selected pulse width
wave_sel_o  out  4  selected wave select
sync_o  out  1  selected sync enable
ring_mod_o  out  1  selected ring-mod enable
voice_ready_i  in  1  generator done pulse
voice_wave_i  in  10  generator output, signed
mix_o  out  12  mixed sample, signed
mix_valid_o  out  1  one-cycle pulse, mix_o updated
busy_o  out  1  frame in progress
overrun_o  out  1  sticky: tick arrived while not IDLE
timeout_o  out  1  sticky: a voice timed out

Behaviour:
- Reset is asynchronous. It forces state IDLE, voice index 0, accumulator 0, wait counter 0, and drives all outputs to 0.
- States: IDLE, START, WAIT, DONE.
  - IDLE: sample_tick_i=1 -> START, voice index=0, accumulator=0.
  - START: start_o=1 for exactly this one cycle -> WAIT, wait counter=0.
  - WAIT: on voice_ready_i=1, add the voice contribution to the accumulator. On a timeout, add 0 and set timeout_o. In both cases go to START with the next voice index, or to DONE if the index is 2. Otherwise increment the wait counter; a timeout occurs when the counter reaches TIMEOUT_CYCLES-1 with no ready.
  - DONE: mix_valid_o=1 and mix_o equals the final sum in this cycle -> IDLE.
- start_o, act_voice_o and the mux outputs are combinational from the state and voice index registers. act_voice_o and all selected control words stay stable from the START cycle through the WAIT cycle in which ready is sampled.
- In IDLE, act_voice_o=0 and the mux outputs show voice 0.
- busy_o is 1 in every state except IDLE.
- voice_ready_i is ignored outside WAIT. A late ready after a timeout is not accumulated.
- Contribution of a voice:
  - prod = voice_wave_i (signed 10) times {1'b0, env} (signed 9), giving a signed 19-bit product.
  - scaled = prod >>> 8, arithmetic shift, range -510..509.
  - If mute_i[v]=1 the contribution is 0. The generator is still started for a muted voice so its phase keeps advancing.
- The accumulator is signed 12-bit, range -1530..1527, so it never overflows.
- mix_o is loaded from the accumulator on entry to DONE and holds its value until the next DONE.
- Latency: with ready arriving L cycles after start_o, mix_valid_o rises 3*(L+1)+1 cycles after the tick cycle. For the generator, L=3, so mix_valid_o rises at tick+13.
- Timing checkpoints for L=3: start_o is high at tick+1, tick+5 and tick+9.
- A sample_tick_i seen in any state other than IDLE is dropped and sets overrun_o.
- Sticky flags:
  - status_clr_i clears overrun_o and timeout_o.
  - If a set event occurs in the same cycle as status_clr_i, the set wins.
- Env and control inputs are sampled live. Changes take effect from the next START of the affected voice.

Test Plan:
- Reset mid-frame (assert at tick+6) -> all outputs 0 next cycle; after release, a new tick yields a normal frame.
- Waves 100, -200, 511 with env 255,128,255 -> contributions 99, -100, 509 -> mix_o=508, mix_valid_o at tick+13 with L=3.
- Waves -512 x3 with env 255 x3 -> mix_o=-1530. Same waves with mute_i=3'b111 -> mix_o=0, and start_o still pulses 3 times.
- Second tick at tick+5 -> ignored, overrun_o=1, frame result unchanged. status_clr_i then clears overrun_o, and status_clr_i together with a new overrun leaves overrun_o=1.
- Voice 1 ready suppressed -> voice 1 contributes 0, timeout_o=1, act_voice_o=2 starts after TIMEOUT_CYCLES wait cycles. A late ready is ignored.
- Per voice, check act_voice_o, freq_word_o, pw_word_o, wave_sel_o, sync_o and ring_mod_o match the selected slice and are stable from START to ready. freq_words_i=0x0003_0002_0001 -> freq_word_o reads 1, 2, 3 in order.

Source files
------------

// File: rtl/voice_scheduler_mixer.sv
// Frame scheduler for the sequential 3-voice generator: starts each voice in turn,
// scales every returned waveform by its envelope level and sums them into one signed sample.
module voice_scheduler_mixer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sample_tick_i,
    input  logic        status_clr_i,
    input  logic [47:0] freq_words_i,
    input  logic [35:0] pw_words_i,
    input  logic [11:0] wave_sels_i,
    input  logic [2:0]  sync_en_i,
    input  logic [2:0]  ring_en_i,
    input  logic [23:0] env_levels_i,
    input  logic [2:0]  mute_i,
    output logic        start_o,
    output logic [1:0]  act_voice_o,
    output logic [15:0] freq_word_o,
    output logic [11:0] pw_word_o,
    output logic [3:0]  wave_sel_o,
    output logic        sync_o,
    output logic        ring_mod_o,
    input  logic        voice_ready_i,
    input  logic [9:0]  voice_wave_i,
    output logic [11:0] mix_o,
    output logic        mix_valid_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         voice_q, voice_d;
    logic signed [11:0] acc_q, acc_d;
    logic signed [11:0] mix_q, mix_d;
    logic [7:0]         wait_q, wait_d;
    logic               overrun_q, timeout_q;
    logic               set_overrun, set_timeout;

    logic [7:0]         env_sel;
    logic               mute_sel;
    logic signed [18:0] wave_x, env_x, prod;
    logic signed [11:0] contrib;

    always_comb begin
        freq_word_o = freq_words_i[15:0];
        pw_word_o   = pw_words_i[11:0];
        wave_sel_o  = wave_sels_i[3:0];
        sync_o      = sync_en_i[0];
        ring_mod_o  = ring_en_i[0];
        env_sel     = env_levels_i[7:0];
        mute_sel    = mute_i[0];
        case (voice_q)
            2'd1: begin
                freq_word_o = freq_words_i[31:16];
                pw_word_o   = pw_words_i[23:12];
                wave_sel_o  = wave_sels_i[7:4];
                sync_o      = sync_en_i[1];
                ring_mod_o  = ring_en_i[1];
                env_sel     = env_levels_i[15:8];
                mute_sel    = mute_i[1];
            end
            2'd2: begin
                freq_word_o = freq_words_i[47:32];
                pw_word_o   = pw_words_i[35:24];
                wave_sel_o  = wave_sels_i[11:8];
                sync_o      = sync_en_i[2];
                ring_mod_o  = ring_en_i[2];
                env_sel     = env_levels_i[23:16];
                mute_sel    = mute_i[2];
            end
            default: ;
        endcase
    end

    // Envelope is unsigned, so it enters the signed product zero-extended.
    assign wave_x  = {{9{voice_wave_i[9]}}, voice_wave_i};
    assign env_x   = {11'd0, env_sel};
    assign prod    = wave_x * env_x;
    assign contrib = mute_sel ? 12'sd0 : {prod[18], prod[18:8]};

    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        acc_d       = acc_q;
        wait_d      = wait_q;
        mix_d       = mix_q;
        set_timeout = 1'b0;
        set_overrun = sample_tick_i && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sample_tick_i) begin
                    state_d = START;
                    voice_d = 2'd0;
                    acc_d   = '0;
                end
            end
            START: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (voice_ready_i || (wait_q == WAIT_LAST)) begin
                    if (voice_ready_i) begin
                        acc_d = acc_q + contrib;
                    end else begin
                        set_timeout = 1'b1;
                    end
                    if (voice_q == 2'd2) begin
                        state_d = DONE;
                        mix_d   = acc_d;
                    end else begin
                        state_d = START;
                        voice_d = voice_q + 2'd1;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                voice_d = 2'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // A flag event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            voice_q   <= 2'd0;
            acc_q     <= '0;
            mix_q     <= '0;
            wait_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            acc_q     <= acc_d;
            mix_q     <= mix_d;
            wait_q    <= wait_d;
            overrun_q <= set_overrun | (overrun_q & ~status_clr_i);
            timeout_q <= set_timeout | (timeout_q & ~status_clr_i);
        end
    end

    assign start_o     = (state_q == START);
    assign act_voice_o = voice_q;
    assign busy_o      = (state_q != IDLE);
    assign mix_valid_o = (state_q == DONE);
    assign mix_o       = mix_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_voice_scheduler_mixer.sv
// Directed bench for voice_scheduler_mixer: a behavioural generator answers each start
// after a per-voice latency; frames are checked for sum, timing, muxing and sticky flags.
module tb_voice_scheduler_mixer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sample_tick_i = 1'b0;
    logic        status_clr_i = 1'b0;
    logic [47:0] freq_words_i;
    logic [35:0] pw_words_i;
    logic [11:0] wave_sels_i;
    logic [2:0]  sync_en_i;
    logic [2:0]  ring_en_i;
    logic [23:0] env_levels_i;
    logic [2:0]  mute_i;
    logic        start_o;
    logic [1:0]  act_voice_o;
    logic [15:0] freq_word_o;
    logic [11:0] pw_word_o;
    logic [3:0]  wave_sel_o;
    logic        sync_o;
    logic        ring_mod_o;
    logic        voice_ready_i = 1'b0;
    logic [9:0]  voice_wave_i = '0;
    logic [11:0] mix_o;
    logic        mix_valid_o;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;

    voice_scheduler_mixer #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sample_tick_i(sample_tick_i), .status_clr_i(status_clr_i),
        .freq_words_i(freq_words_i), .pw_words_i(pw_words_i), .wave_sels_i(wave_sels_i),
        .sync_en_i(sync_en_i), .ring_en_i(ring_en_i), .env_levels_i(env_levels_i), .mute_i(mute_i),
        .start_o(start_o), .act_voice_o(act_voice_o), .freq_word_o(freq_word_o), .pw_word_o(pw_word_o),
        .wave_sel_o(wave_sel_o), .sync_o(sync_o), .ring_mod_o(ring_mod_o),
        .voice_ready_i(voice_ready_i), .voice_wave_i(voice_wave_i), .mix_o(mix_o),
        .mix_valid_o(mix_valid_o), .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #10 clk_i = ~clk_i;

    typedef struct {
        logic signed [9:0] w0, w1, w2;
        logic [7:0]        e0, e1, e2;
        logic [2:0]        mute;
        int                exp_mix;
    } vec_t;

    int                total = 0;
    int                bad = 0;
    int                lat[3] = '{3, 3, 3};
    logic signed [9:0] waves[3];
    int                gen_cnt = 0;
    logic [1:0]        gen_voice = 2'd0;
    int                nstarts;
    int                start_at[3];
    int                start_v[3];
    int                valid_at;
    int                mix_got;
    int                hold_val;
    vec_t              vecs[8];

    // Generator model: ready pulses lat[v] cycles after the start it answers.
    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gen_cnt       = 0;
            voice_ready_i = 1'b0;
        end else begin
            voice_ready_i = 1'b0;
            if (gen_cnt > 0) begin
                gen_cnt--;
                if (gen_cnt == 0) begin
                    voice_ready_i = 1'b1;
                    voice_wave_i  = waves[gen_voice];
                end
            end
            if (start_o) begin
                gen_cnt   = lat[act_voice_o];
                gen_voice = act_voice_o;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        waves[0]     = v.w0;
        waves[1]     = v.w1;
        waves[2]     = v.w2;
        env_levels_i = {v.e2, v.e1, v.e0};
        mute_i       = v.mute;
    endtask

    task automatic checkMux(input int n, input int v);
        logic [11:0] exp_pw[3]   = '{12'h111, 12'h222, 12'h333};
        logic [3:0]  exp_ws[3]   = '{4'hA, 4'hB, 4'hC};
        logic        exp_sync[3] = '{1'b1, 1'b0, 1'b1};
        logic        exp_ring[3] = '{1'b0, 1'b1, 1'b0};
        checkOutput($sformatf("act_voice_n%0d", n), int'(act_voice_o), v);
        checkOutput($sformatf("freq_n%0d", n), int'(freq_word_o), v + 1);
        checkOutput($sformatf("pw_n%0d", n), int'(pw_word_o), int'(exp_pw[v]));
        checkOutput($sformatf("wave_sel_n%0d", n), int'(wave_sel_o), int'(exp_ws[v]));
        checkOutput($sformatf("sync_n%0d", n), int'(sync_o), int'(exp_sync[v]));
        checkOutput($sformatf("ring_n%0d", n), int'(ring_mod_o), int'(exp_ring[v]));
    endtask

    // Ticks in cycle 0, then samples each later cycle n at its falling edge.
    task automatic runFrame(input int extra_tick_at, input int clr_at, input bit chk_mux);
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        nstarts  = 0;
        valid_at = -1;
        mix_got  = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_i);
            if (start_o) begin
                if (nstarts < 3) begin
                    start_at[nstarts] = n;
                    start_v[nstarts]  = int'(act_voice_o);
                end
                nstarts++;
            end
            if (chk_mux && n <= 12) checkMux(n, (n - 1) / 4);
            if (mix_valid_o) begin
                valid_at = n;
                mix_got  = int'($signed(mix_o));
                break;
            end
            sample_tick_i = (n == extra_tick_at);
            status_clr_i  = (n == clr_at);
        end
        sample_tick_i = 1'b0;
        status_clr_i  = 1'b0;
    endtask

    initial begin
        freq_words_i = {16'd3, 16'd2, 16'd1};
        pw_words_i   = {12'h333, 12'h222, 12'h111};
        wave_sels_i  = {4'hC, 4'hB, 4'hA};
        sync_en_i    = 3'b101;
        ring_en_i    = 3'b010;
        vecs[0] = '{w0: 10'sd100,  w1: -10'sd200, w2: 10'sd511,  e0: 8'd255, e1: 8'd128, e2: 8'd255, mute: 3'b000, exp_mix: 508};
        vecs[1] = '{w0: -10'sd512, w1: -10'sd512, w2: -10'sd512, e0: 8'd255, e1: 8'd255, e2: 8'd255, mute: 3'b000, exp_mix: -1530};
        vecs[2] = '{w0: -10'sd512, w1: -10'sd512, w2: -10'sd512, e0: 8'd255, e1: 8'd255, e2: 8'd255, mute: 3'b111, exp_mix: 0};
        vecs[3] = '{w0: -10'sd1,   w1: -10'sd1,   w2: -10'sd1,   e0: 8'd1,   e1: 8'd1,   e2: 8'd1,   mute: 3'b000, exp_mix: -3};
        vecs[4] = '{w0: 10'sd128,  w1: 10'sd128,  w2: -10'sd256, e0: 8'd2,   e1: 8'd4,   e2: 8'd7,   mute: 3'b000, exp_mix: -4};
        vecs[5] = '{w0: 10'sd100,  w1: -10'sd200, w2: 10'sd511,  e0: 8'd255, e1: 8'd128, e2: 8'd255, mute: 3'b010, exp_mix: 608};
        vecs[6] = '{w0: 10'sd511,  w1: 10'sd0,    w2: -10'sd512, e0: 8'd0,   e1: 8'd255, e2: 8'd128, mute: 3'b000, exp_mix: -256};
        vecs[7] = '{w0: 10'sd511,  w1: 10'sd511,  w2: 10'sd511,  e0: 8'd255, e1: 8'd255, e2: 8'd255, mute: 3'b000, exp_mix: 1527};
        applyStimulus(vecs[0]);

        repeat (3) @(negedge clk_i);
        checkOutput("rst_start", int'(start_o), 0);
        checkOutput("rst_busy", int'(busy_o), 0);
        checkOutput("rst_mix", int'(mix_o), 0);
        checkOutput("rst_valid", int'(mix_valid_o), 0);
        checkOutput("rst_overrun", int'(overrun_o), 0);
        checkOutput("rst_timeout", int'(timeout_o), 0);
        checkOutput("rst_act_voice", int'(act_voice_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("idle_freq", int'(freq_word_o), 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            runFrame(0, 0, i == 0);
            checkOutput($sformatf("mix_v%0d", i), mix_got, vecs[i].exp_mix);
            checkOutput($sformatf("valid_at_v%0d", i), valid_at, 13);
            checkOutput($sformatf("starts_v%0d", i), nstarts, 3);
            checkOutput($sformatf("start1_at_v%0d", i), start_at[1], 5);
            checkOutput($sformatf("start2_at_v%0d", i), start_at[2], 9);
            @(negedge clk_i);
            checkOutput($sformatf("valid_drop_v%0d", i), int'(mix_valid_o), 0);
            checkOutput($sformatf("mix_hold_v%0d", i), int'($signed(mix_o)), vecs[i].exp_mix);
            checkOutput($sformatf("idle_busy_v%0d", i), int'(busy_o), 0);
            checkOutput($sformatf("idle_voice_v%0d", i), int'(act_voice_o), 0);
        end

        // Voice 1 never answers in time; its ready lands one cycle after the timeout.
        applyStimulus(vecs[0]);
        lat[1] = 17;
        checkOutput("timeout_pre", int'(timeout_o), 0);
        runFrame(0, 0, 1'b0);
        lat[1] = 3;
        checkOutput("to_starts", nstarts, 3);
        checkOutput("to_start2_at", start_at[2], 22);
        checkOutput("to_start2_voice", start_v[2], 2);
        checkOutput("to_valid_at", valid_at, 26);
        checkOutput("to_mix", mix_got, 608);
        checkOutput("to_flag", int'(timeout_o), 1);
        @(negedge clk_i);
        status_clr_i = 1'b1;
        @(negedge clk_i);
        status_clr_i = 1'b0;
        checkOutput("to_cleared", int'(timeout_o), 0);

        runFrame(5, 0, 1'b0);
        checkOutput("ovr_mix", mix_got, 508);
        checkOutput("ovr_valid_at", valid_at, 13);
        checkOutput("ovr_flag", int'(overrun_o), 1);
        @(negedge clk_i);
        status_clr_i = 1'b1;
        @(negedge clk_i);
        status_clr_i = 1'b0;
        checkOutput("ovr_cleared", int'(overrun_o), 0);
        runFrame(3, 3, 1'b0);
        checkOutput("ovr_set_wins", int'(overrun_o), 1);
        checkOutput("ovr_mix2", mix_got, 508);

        // Reset dropped in the middle of voice 1's wait.
        applyStimulus(vecs[1]);
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            sample_tick_i = 1'b0;
        end
        checkOutput("mid_busy", int'(busy_o), 1);
        checkOutput("mid_voice", int'(act_voice_o), 1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("mrst_start", int'(start_o), 0);
        checkOutput("mrst_busy", int'(busy_o), 0);
        checkOutput("mrst_mix", int'(mix_o), 0);
        checkOutput("mrst_valid", int'(mix_valid_o), 0);
        checkOutput("mrst_overrun", int'(overrun_o), 0);
        checkOutput("mrst_timeout", int'(timeout_o), 0);
        checkOutput("mrst_voice", int'(act_voice_o), 0);
        rst_ni = 1'b1;
        applyStimulus(vecs[0]);
        runFrame(0, 0, 1'b0);
        checkOutput("post_rst_mix", mix_got, 508);
        checkOutput("post_rst_valid_at", valid_at, 13);
        checkOutput("post_rst_starts", nstarts, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
